// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the fetch PC, issues one-at-a-time word requests to
// instruction memory and buffers {pc, instr} pairs in a small FIFO for decode.
// Redirects flush all wrong-path state; an in-flight request is drained in
// DISCARD so its data never reaches the FIFO.
// Optional feature macro: RISCV_FETCH_MISALIGN_EN (sticky misaligned-redirect fault).
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00010000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_fault
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, DISCARD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       hold_addr_q, hold_addr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [31:0]       pc_mem_q [DEPTH];
    logic [31:0]       pc_mem_d [DEPTH];
    logic [31:0]       data_mem_q [DEPTH];
    logic [31:0]       data_mem_d [DEPTH];
    logic              push, pop;
    logic              fetch_en;
    logic [31:0]       target_pc;

`ifdef RISCV_FETCH_MISALIGN_EN
    logic fault_q, fault_d;
    assign fetch_en       = !fault_q;
    assign target_pc      = redirect_pc;
    assign misalign_fault = fault_q;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign fetch_en       = 1'b1;
    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign misalign_fault = 1'b0;
`endif

    // Request and FIFO-head outputs; all come from registered state (reset only masks the request)
    always_comb begin
        imem_req   = !reset && ((state_q == DISCARD) || (fetch_en && (count_q < CW'(DEPTH))));
        imem_addr  = (state_q == DISCARD) ? hold_addr_q : fetch_pc_q;
        inst_valid = (count_q != '0);
        inst_data  = inst_valid ? data_mem_q[head_q] : '0;
        inst_pc    = inst_valid ? pc_mem_q[head_q] : '0;
    end

    // Next-state: redirect beats push/pop; DISCARD drains the stale request before returning to RUN
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        pc_mem_d    = pc_mem_q;
        data_mem_d  = data_mem_q;
        push        = 1'b0;
        pop         = 1'b0;
`ifdef RISCV_FETCH_MISALIGN_EN
        fault_d     = fault_q;
`endif
        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            if (state_q == RUN) begin
                // Request still waiting: keep its address on the bus and drop its data later
                if (imem_req && !imem_ready) begin
                    state_d     = DISCARD;
                    hold_addr_d = fetch_pc_q;
                end
            end else if (imem_ready) begin
                // The stale request completes this cycle regardless of the new redirect
                state_d = RUN;
            end
`ifdef RISCV_FETCH_MISALIGN_EN
            fault_d = |redirect_pc[1:0];
`endif
        end else begin
            pop  = inst_valid && inst_ready;
            push = (state_q == RUN) && imem_req && imem_ready;
            if ((state_q == DISCARD) && imem_ready) state_d = RUN;
            if (push) begin
                pc_mem_d[tail_q]   = fetch_pc_q;
                data_mem_d[tail_q] = imem_rdata;
                tail_d             = tail_q + PW'(1);
                fetch_pc_d         = fetch_pc_q + 32'd4;
            end
            if (pop) head_d = head_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            hold_addr_q <= '0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
`ifdef RISCV_FETCH_MISALIGN_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            pc_mem_q    <= pc_mem_d;
            data_mem_q  <= data_mem_d;
`ifdef RISCV_FETCH_MISALIGN_EN
            fault_q     <= fault_d;
`endif
        end
    end
endmodule
